// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state type and default width for the bit-serial adder
package serial_add_pkg;

  // Controller states: waiting for operands, shifting bits, holding the result
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_bit.sv
// rtl/fa_bit.sv - one-bit full adder shared across all bit positions
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract controller; SERIAL_ADD_OVF_EN adds signed overflow
import serial_add_pkg::*;

module serial_add_ctrl #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  assign last_bit = (cnt == LAST_BIT);

  // The single full adder works on the current LSBs and the running carry
  fa_bit u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .c  (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs, decoded from state only
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand load, per-bit shifting and carry tracking; subtract is A + ~B + 1
`ifdef SERIAL_ADD_OVF_EN
  logic ovf_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_reg <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= sub ? ~b : b;
            carry   <= sub;
            cnt     <= '0;
            res_reg <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_reg <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          res_reg <= {fa_s, res_reg[WIDTH-1:1]};
          carry   <= fa_co;
          // Hold the counter on the last bit so it never wraps
          if (!last_bit) cnt <= cnt + CNT_W'(1);
`ifdef SERIAL_ADD_OVF_EN
          // Carry into the MSB differs from carry out exactly on signed overflow
          if (last_bit) ovf_reg <= carry ^ fa_co;
`endif
        end
        default: ;
      endcase
    end
  end

  assign sum  = res_reg;
  assign cout = carry;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_reg;
`else
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl with an arithmetic reference model
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int passed = 0;
  int total  = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values
  task automatic model(input int ia, input int ib, input bit is_sub,
                       output int es, output bit ec, output bit eo);
    int sa, sb, r;
    if (is_sub) begin
      es = (ia - ib) & 255;
      ec = (ia >= ib);
    end else begin
      es = (ia + ib) & 255;
      ec = ((ia + ib) > 255);
    end
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    r  = is_sub ? sa - sb : sa + sb;
`ifdef SERIAL_ADD_OVF_EN
    eo = (r > 127) || (r < -128);
`else
    eo = 1'b0;
`endif
  endtask

  task automatic do_op(input int ia, input int ib, input bit is_sub, input int hold);
    int es;
    bit ec, eo;
    int cycles;
    logic [7:0] s_hold;
    model(ia, ib, is_sub, es, ec, eo);
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    a = 8'(ia);
    b = 8'(ib);
    sub = is_sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    sub = 1'($urandom);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("latency", cycles, 8);
    check("sum", sum, es);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    s_hold = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_sum", sum, s_hold);
      check("hold_cout", cout, ec);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ret_valid", out_valid, 0);
    check("ret_ready", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ready", in_ready, 1);
    rst = 1'b0;

    do_op(100, 27, 1'b0, 0);
    do_op(255, 1, 1'b0, 0);
    do_op(127, 1, 1'b0, 0);
    do_op(5, 7, 1'b1, 0);
    do_op(7, 5, 1'b1, 0);
    do_op(128, 1, 1'b1, 0);
    do_op(0, 0, 1'b1, 0);
    do_op(200, 100, 1'b0, 5);

    // Asynchronous reset during the third RUN cycle
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd200;
    b = 8'd99;
    sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_sum", sum, 0);
    check("arst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    do_op(3, 4, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
